// File: rtl/ship_pkg.sv
// Shared ship-systems definitions: FSM state codes, mode codes
// and the reserve saturation ceiling used by the supply blocks.
package ship_pkg;

    // Binary FSM state codes for the resupply sequencer
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    // One-hot ship mode codes
    localparam logic [3:0] MODE_DOCK   = 4'b0001;
    localparam logic [3:0] MODE_ATTACK = 4'b0010;

    // Default reserve saturation ceiling
    localparam int RESERVE_MAX_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        XFER   = ST_XFER,
        SETTLE = ST_SETTLE
    } rs_state_t;

endpackage

// File: rtl/sat_accum.sv
// Saturating reserve register: q <= clip(q - sub + add) each edge.
// Ports: clk, rst (sync, active-high), add/sub (AW), q (W), overflow.
module sat_accum #(
    parameter int W   = 10,
    parameter int AW  = 9,
    parameter int MAX = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] add,
    input  logic [AW-1:0] sub,
    output logic [W-1:0]  q,
    output logic          overflow
);

    localparam logic [W:0] MAX_W = (W+1)'(MAX);

    logic [W:0] tot;
    logic [W:0] sub_w;
    logic [W:0] diff;
    logic       sat;

    // One extra bit of headroom so add cannot wrap before the clip.
    // The underflow guard is defensive: the grant never exceeds q.
    always_comb begin
        tot   = {1'b0, q} + (W+1)'(add);
        sub_w = (W+1)'(sub);
        diff  = '0;
        if (tot >= sub_w) begin
            diff = tot - sub_w;
        end
        sat = (diff > MAX_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            overflow <= 1'b0;
        end else begin
            q        <= sat ? MAX_W[W-1:0] : diff[W-1:0];
            overflow <= sat;
        end
    end

endmodule

// File: rtl/ammo_resupply.sv
// Ammo resupply: accepts crates into a saturating reserve and meters
// rounds into the magazine with a load pulse at a programmable rate.
// Ports: clk, rst (sync, active-high), mode_selector, fire,
//   crate_valid/crate_rounds/crate_ready (crate handshake),
//   mag_count/mag_max (magazine state), load_rate,
//   load_en/load_amount (magazine add pulse), reserve, busy, overflow.
module ammo_resupply
    import ship_pkg::*;
#(
    parameter int         N           = 9,
    parameter int         R           = 10,
    parameter int         RESERVE_MAX = RESERVE_MAX_DEF,
    parameter logic [3:0] DOCK_MODE   = MODE_DOCK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   mode_selector,
    input  logic         fire,
    input  logic         crate_valid,
    input  logic [N-1:0] crate_rounds,
    output logic         crate_ready,
    input  logic [N-1:0] mag_count,
    input  logic [N-1:0] mag_max,
    input  logic [N-1:0] load_rate,
    output logic         load_en,
    output logic [N-1:0] load_amount,
    output logic [R-1:0] reserve,
    output logic         busy,
    output logic         overflow
);

    rs_state_t state;

    logic [N-1:0] room;
    logic [N-1:0] rate_eff;
    logic [R-1:0] room_r;
    logic [R-1:0] rate_r;
    logic [R-1:0] min_r;
    logic [N-1:0] amount;
    logic [N-1:0] accepted;
    logic         go;

    // Crates are always welcome outside reset; the reserve clips.
    assign crate_ready = ~rst;
    assign accepted    = (crate_valid & crate_ready) ? crate_rounds : '0;

    // Grant = min(rate, reserve, room); mag_count above mag_max
    // simply reads as a full magazine.
    always_comb begin
        room     = (mag_count < mag_max) ? (mag_max - mag_count) : '0;
        rate_eff = (load_rate == '0) ? N'(1) : load_rate;
        room_r   = R'(room);
        rate_r   = R'(rate_eff);
        min_r    = rate_r;
        if (reserve < min_r) begin
            min_r = reserve;
        end
        if (room_r < min_r) begin
            min_r = room_r;
        end
        amount = min_r[N-1:0];
    end

    assign go = (mode_selector == DOCK_MODE) && !fire && (amount != '0);

    // Reserve drains by the pulse currently on load_amount, so the
    // subtraction lands on the same edge the magazine takes the add.
    sat_accum #(
        .W   (R),
        .AW  (N),
        .MAX (RESERVE_MAX)
    ) u_reserve (
        .clk      (clk),
        .rst      (rst),
        .add      (accepted),
        .sub      (load_amount),
        .q        (reserve),
        .overflow (overflow)
    );

    // Grant is re-evaluated in XFER and registered, so the pulse is
    // visible during SETTLE; the magazine has absorbed it before the
    // next IDLE evaluation of room.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            load_en     <= 1'b0;
            load_amount <= '0;
            busy        <= 1'b0;
        end else begin
            load_en     <= 1'b0;
            load_amount <= '0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state <= XFER;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                XFER: begin
                    load_en     <= 1'b1;
                    load_amount <= amount;
                    state       <= SETTLE;
                    busy        <= 1'b1;
                end
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ammo_resupply.sv
// Self-checking bench for ammo_resupply: directed scenarios plus a
// randomized run against a cycle-level behavioural reference model.
module tb_ammo_resupply;

    localparam int         N      = 9;
    localparam int         R      = 10;
    localparam int         RMAX   = 1000;
    localparam logic [3:0] DOCK   = 4'b0001;
    localparam logic [3:0] ATTACK = 4'b0010;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   mode_selector = ATTACK;
    logic         fire = 1'b0;
    logic         crate_valid = 1'b0;
    logic [N-1:0] crate_rounds = '0;
    logic         crate_ready;
    logic [N-1:0] mag_count = '0;
    logic [N-1:0] mag_max = '0;
    logic [N-1:0] load_rate = '0;
    logic         load_en;
    logic [N-1:0] load_amount;
    logic [R-1:0] reserve;
    logic         busy;
    logic         overflow;

    int passed = 0;
    int total  = 0;

    // Reference model state (values visible after the latest edge)
    int m_res   = 0;
    int m_amt   = 0;
    bit m_le    = 0;
    bit m_ovf   = 0;
    bit m_busy  = 0;
    int m_since = 0;  // 0: no grant in flight, else cycles since grant
    bit auto_mag = 0;

    ammo_resupply dut (
        .clk           (clk),
        .rst           (rst),
        .mode_selector (mode_selector),
        .fire          (fire),
        .crate_valid   (crate_valid),
        .crate_rounds  (crate_rounds),
        .crate_ready   (crate_ready),
        .mag_count     (mag_count),
        .mag_max       (mag_max),
        .load_rate     (load_rate),
        .load_en       (load_en),
        .load_amount   (load_amount),
        .reserve       (reserve),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Advance one clock: model computes the effect of the current
    // inputs, then the edge happens and state is committed.
    task automatic tick();
        int room, rate, amt, acc, nres, nmag, nsince, namt;
        bit nle, novf;
        room = (int'(mag_count) < int'(mag_max)) ?
               int'(mag_max) - int'(mag_count) : 0;
        rate = (load_rate == 0) ? 1 : int'(load_rate);
        amt  = imin(rate, imin(m_res, room));
        nmag = int'(mag_count);
        if (m_le) nmag += m_amt;
        if (fire && nmag > 0) nmag -= 1;
        if (nmag > 511) nmag = 511;
        if (rst) begin
            nres = 0; nle = 0; namt = 0; novf = 0; nsince = 0;
        end else begin
            acc  = crate_valid ? int'(crate_rounds) : 0;
            nres = m_res - m_amt + acc;
            if (nres < 0) nres = 0;
            novf = (nres > RMAX);
            if (novf) nres = RMAX;
            nle = 0; namt = 0; nsince = 0;
            if (m_since == 0) begin
                if (mode_selector == DOCK && !fire && amt > 0) nsince = 1;
            end else if (m_since == 1) begin
                nle = 1; namt = amt; nsince = 2;
            end
        end
        @(posedge clk);
        #1;
        m_res   = nres;
        m_le    = nle;
        m_amt   = namt;
        m_ovf   = novf;
        m_since = nsince;
        m_busy  = (nsince != 0);
        if (auto_mag) mag_count = nmag[N-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        crate_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        crate_valid = 1'b1;
        crate_rounds = 9'd50;
        mode_selector = DOCK;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (crate_ready !== 1'b0)
                $display("FAIL reset_ready: got %b want 0", crate_ready);
            else passed++;
            total++;
            if (reserve !== 10'd0)
                $display("FAIL reset_reserve: got %0d want 0", reserve);
            else passed++;
            total++;
            if (load_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0)
                $display("FAIL reset_outs: got le=%b busy=%b ovf=%b want 0",
                         load_en, busy, overflow);
            else passed++;
        end
        rst = 1'b0;
        crate_valid = 1'b0;
        #1;
        total++;
        if (crate_ready !== 1'b1)
            $display("FAIL release_ready: got %b want 1", crate_ready);
        else passed++;
        tick();
    endtask

    task automatic test_basic_refill();
        int amts[$];
        int when[$];
        do_reset();
        mode_selector = DOCK;
        mag_max = 9'd500;
        mag_count = 9'd490;
        load_rate = 9'd4;
        auto_mag = 1;
        crate_valid = 1'b1;
        crate_rounds = 9'd20;
        tick();
        crate_valid = 1'b0;
        total++;
        if (reserve !== 10'd20)
            $display("FAIL refill_accept: got %0d want 20", reserve);
        else passed++;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (load_en === 1'b1) begin
                amts.push_back(int'(load_amount));
                when.push_back(c);
            end
            total++;
            if (load_en !== m_le || load_amount !== N'(m_amt))
                $display("FAIL refill_cycle%0d: got le=%b amt=%0d want le=%b amt=%0d",
                         c, load_en, load_amount, m_le, m_amt);
            else passed++;
        end
        total++;
        if (amts.size() != 3)
            $display("FAIL refill_npulses: got %0d want 3", amts.size());
        else passed++;
        if (amts.size() == 3) begin
            total++;
            if (amts[0] != 4 || amts[1] != 4 || amts[2] != 2)
                $display("FAIL refill_amounts: got %0d,%0d,%0d want 4,4,2",
                         amts[0], amts[1], amts[2]);
            else passed++;
            total++;
            if (when[1] - when[0] != 3 || when[2] - when[1] != 3)
                $display("FAIL refill_spacing: got %0d,%0d want 3,3",
                         when[1] - when[0], when[2] - when[1]);
            else passed++;
        end
        total++;
        if (reserve !== 10'd10 || busy !== 1'b0)
            $display("FAIL refill_end: got res=%0d busy=%b want res=10 busy=0",
                     reserve, busy);
        else passed++;
    endtask

    task automatic test_reserve_limited();
        int n = 0;
        int sum = 0;
        do_reset();
        mode_selector = DOCK;
        mag_max = 9'd200;
        mag_count = 9'd100;
        load_rate = 9'd8;
        crate_valid = 1'b1;
        crate_rounds = 9'd3;
        tick();
        crate_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (load_en === 1'b1) begin
                n++;
                sum += int'(load_amount);
            end
        end
        total++;
        if (n != 1 || sum != 3)
            $display("FAIL limited_pulse: got n=%0d amt=%0d want n=1 amt=3", n, sum);
        else passed++;
        total++;
        if (reserve !== 10'd0 || busy !== 1'b0)
            $display("FAIL limited_end: got res=%0d busy=%b want 0 0", reserve, busy);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        auto_mag = 0;
        mode_selector = ATTACK;
        crate_valid = 1'b1;
        crate_rounds = 9'd500;
        tick();
        crate_rounds = 9'd490;
        tick();
        total++;
        if (reserve !== 10'd990 || overflow !== 1'b0)
            $display("FAIL sat_pre: got res=%0d ovf=%b want 990 0", reserve, overflow);
        else passed++;
        crate_rounds = 9'd50;
        tick();
        crate_valid = 1'b0;
        total++;
        if (reserve !== 10'd1000 || overflow !== 1'b1)
            $display("FAIL sat_clip: got res=%0d ovf=%b want 1000 1", reserve, overflow);
        else passed++;
        tick();
        total++;
        if (overflow !== 1'b0 || reserve !== 10'd1000)
            $display("FAIL sat_once: got res=%0d ovf=%b want 1000 0", reserve, overflow);
        else passed++;
    endtask

    task automatic test_blocking();
        int bad = 0;
        do_reset();
        auto_mag = 1;
        mode_selector = ATTACK;
        mag_max = 9'd500;
        mag_count = 9'd0;
        load_rate = 9'd5;
        crate_valid = 1'b1;
        crate_rounds = 9'd100;
        tick();
        crate_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (load_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        mode_selector = DOCK;
        fire = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (load_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL blocked: got %0d active cycles want 0", bad);
        else passed++;
        fire = 1'b0;
        tick();
        total++;
        if (load_en !== 1'b0 || busy !== 1'b1)
            $display("FAIL unblock_c1: got le=%b busy=%b want 0 1", load_en, busy);
        else passed++;
        tick();
        total++;
        if (load_en !== 1'b1 || load_amount !== 9'd5)
            $display("FAIL unblock_c2: got le=%b amt=%0d want 1 5", load_en, load_amount);
        else passed++;
    endtask

    task automatic test_concurrency();
        do_reset();
        auto_mag = 1;
        mode_selector = ATTACK;
        mag_max = 9'd500;
        mag_count = 9'd0;
        load_rate = 9'd4;
        crate_valid = 1'b1;
        crate_rounds = 9'd10;
        tick();
        crate_valid = 1'b0;
        mode_selector = DOCK;
        tick();
        tick();
        total++;
        if (load_en !== 1'b1 || load_amount !== 9'd4)
            $display("FAIL conc_pulse: got le=%b amt=%0d want 1 4", load_en, load_amount);
        else passed++;
        crate_valid = 1'b1;
        crate_rounds = 9'd7;
        tick();
        crate_valid = 1'b0;
        total++;
        if (reserve !== 10'd13)
            $display("FAIL conc_reserve: got %0d want 13", reserve);
        else passed++;
        tick();
        tick();
        total++;
        if (load_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL settle_setup: got le=%b busy=%b want 1 1", load_en, busy);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if (reserve !== 10'd0 || load_en !== 1'b0 || busy !== 1'b0 || load_amount !== 9'd0)
            $display("FAIL rst_settle: got res=%0d le=%b busy=%b amt=%0d want 0 0 0 0",
                     reserve, load_en, busy, load_amount);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (load_en !== 1'b0 || reserve !== 10'd0)
            $display("FAIL rst_after: got le=%b res=%0d want 0 0", load_en, reserve);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        auto_mag = 1;
        mag_max = 9'd300;
        mag_count = 9'd0;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            mode_selector = ($urandom_range(0, 9) < 7) ? DOCK :
                            (($urandom_range(0, 1) == 0) ? ATTACK : 4'b0100);
            fire = ($urandom_range(0, 9) == 0);
            crate_valid = ($urandom_range(0, 5) == 0);
            crate_rounds = N'($urandom_range(0, 511));
            load_rate = N'($urandom_range(0, 12));
            if ($urandom_range(0, 59) == 0) mag_max = N'($urandom_range(0, 511));
            if ($urandom_range(0, 39) == 0) mag_count = N'($urandom_range(0, 511));
            tick();
            total++;
            if (load_en !== m_le || load_amount !== N'(m_amt) ||
                reserve !== R'(m_res) || busy !== m_busy || overflow !== m_ovf)
                $display("FAIL rand_c%0d: got le=%b amt=%0d res=%0d busy=%b ovf=%b want le=%b amt=%0d res=%0d busy=%b ovf=%b",
                         c, load_en, load_amount, reserve, busy, overflow,
                         m_le, m_amt, m_res, m_busy, m_ovf);
            else passed++;
        end
        rst = 1'b0;
        fire = 1'b0;
        crate_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_reserve_limited();
        test_saturation();
        test_blocking();
        test_concurrency();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
